// File: rtl/wheel_sim_ctrl_if.sv
// Configuration handshake bundle for the crank-wheel simulator.
// The master offers a config; the slave accepts it, or flags it as rejected.
interface wheel_sim_ctrl_if #(
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned TOOTH_W = 8
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [CNT_W-1:0]   cfg_half_period;
    logic [TOOTH_W-1:0] cfg_teeth;
    logic [3:0]         cfg_missing;
    logic               cfg_err;

    modport master (
        output cfg_valid, cfg_half_period, cfg_teeth, cfg_missing,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_half_period, cfg_teeth, cfg_missing,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/wheel_sim_ctrl.sv
// N-minus-M missing-tooth crank wheel generator.
// Config is double-buffered and applied only on revolution boundaries.
module wheel_sim_ctrl #(
    parameter int unsigned CNT_W   = 24,
    parameter int unsigned TOOTH_W = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               enable,
    wheel_sim_ctrl_if.slave    cfg,
    output logic               vrout,
    output logic [TOOTH_W-1:0] tooth_idx,
    output logic               sync_pulse,
    output logic               running
);
    typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

    state_e             state_q, state_d;
    logic [TOOTH_W:0]   slot_q, slot_d;
    logic [CNT_W-1:0]   presc_q, presc_d;
    logic               vrout_q, vrout_d;
    logic [TOOTH_W-1:0] tooth_q, tooth_d;
    logic               sync_q, sync_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   act_hp_q, act_hp_d, sh_hp_q, sh_hp_d;
    logic [TOOTH_W-1:0] act_teeth_q, act_teeth_d, sh_teeth_q, sh_teeth_d;
    logic [3:0]         act_miss_q, act_miss_d, sh_miss_q, sh_miss_d;
    logic               act_valid_q, act_valid_d;
    logic               pending_q, pending_d;

    logic               fire, cfg_bad, presc_last, slot_last, at_boundary, apply;
    logic [TOOTH_W:0]   slot_inc, tooth_bound;

    assign fire    = cfg.cfg_valid && !pending_q;
    assign cfg_bad = (cfg.cfg_half_period == '0) || (cfg.cfg_teeth < TOOTH_W'(2)) ||
                     ({{TOOTH_W{1'b0}}, cfg.cfg_missing} >= {4'b0000, cfg.cfg_teeth});

    assign presc_last  = (presc_q == act_hp_q - CNT_W'(1));
    assign slot_last   = (slot_q == {act_teeth_q, 1'b0} - (TOOTH_W+1)'(1));
    assign at_boundary = (state_q != StIdle) && presc_last && slot_last;
    // Pending config is committed straight away when idle, else only at a revolution edge.
    assign apply       = pending_q && ((state_q == StIdle) || at_boundary);
    assign slot_inc    = slot_q + (TOOTH_W+1)'(1);
    assign tooth_bound = {act_teeth_q - TOOTH_W'(act_miss_q), 1'b0};

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        presc_d     = presc_q;
        vrout_d     = vrout_q;
        tooth_d     = tooth_q;
        sync_d      = 1'b0;
        err_d       = fire && cfg_bad;
        act_hp_d    = act_hp_q;
        act_teeth_d = act_teeth_q;
        act_miss_d  = act_miss_q;
        act_valid_d = act_valid_q;
        sh_hp_d     = sh_hp_q;
        sh_teeth_d  = sh_teeth_q;
        sh_miss_d   = sh_miss_q;
        pending_d   = pending_q;

        if (fire && !cfg_bad) begin
            sh_hp_d    = cfg.cfg_half_period;
            sh_teeth_d = cfg.cfg_teeth;
            sh_miss_d  = cfg.cfg_missing;
            pending_d  = 1'b1;
        end
        if (apply) begin
            act_hp_d    = sh_hp_q;
            act_teeth_d = sh_teeth_q;
            act_miss_d  = sh_miss_q;
            act_valid_d = 1'b1;
            pending_d   = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                vrout_d = 1'b0;
                tooth_d = '0;
                if (enable && act_valid_q) begin
                    state_d = StRun;
                    slot_d  = '0;
                    presc_d = '0;
                    vrout_d = 1'b1;
                    sync_d  = 1'b1;
                end
            end
            StRun, StStop: begin
                state_d = enable ? StRun : StStop;
                if (!presc_last) begin
                    presc_d = presc_q + CNT_W'(1);
                end else if (slot_last) begin
                    presc_d = '0;
                    slot_d  = '0;
                    tooth_d = '0;
                    vrout_d = enable;
                    sync_d  = enable;
                    if (!enable) state_d = StIdle;
                end else begin
                    presc_d = '0;
                    slot_d  = slot_inc;
                    tooth_d = slot_inc[TOOTH_W:1];
                    vrout_d = (slot_inc < tooth_bound) ? ~slot_inc[0] : 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            slot_q      <= '0;
            presc_q     <= '0;
            vrout_q     <= 1'b0;
            tooth_q     <= '0;
            sync_q      <= 1'b0;
            err_q       <= 1'b0;
            act_hp_q    <= '0;
            act_teeth_q <= '0;
            act_miss_q  <= '0;
            act_valid_q <= 1'b0;
            sh_hp_q     <= '0;
            sh_teeth_q  <= '0;
            sh_miss_q   <= '0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            presc_q     <= presc_d;
            vrout_q     <= vrout_d;
            tooth_q     <= tooth_d;
            sync_q      <= sync_d;
            err_q       <= err_d;
            act_hp_q    <= act_hp_d;
            act_teeth_q <= act_teeth_d;
            act_miss_q  <= act_miss_d;
            act_valid_q <= act_valid_d;
            sh_hp_q     <= sh_hp_d;
            sh_teeth_q  <= sh_teeth_d;
            sh_miss_q   <= sh_miss_d;
            pending_q   <= pending_d;
        end
    end

    assign cfg.cfg_ready = !pending_q;
    assign cfg.cfg_err   = err_q;
    assign vrout         = vrout_q;
    assign tooth_idx     = tooth_q;
    assign sync_pulse    = sync_q;
    assign running       = (state_q != StIdle);
endmodule

// File: tb/tb_wheel_sim_ctrl.sv
// Scoreboard bench: a revolution-position model predicts every output cycle by cycle.
module tb_wheel_sim_ctrl;
    localparam int unsigned CNT_W   = 24;
    localparam int unsigned TOOTH_W = 8;

    typedef struct {
        bit vr;
        int tooth;
        bit sync;
        bit run;
        bit rdy;
        bit err;
    } exp_t;

    logic               clock;
    logic               reset_n;
    logic               enable;
    logic               vrout;
    logic [TOOTH_W-1:0] tooth_idx;
    logic               sync_pulse;
    logic               running;

    wheel_sim_ctrl_if #(.CNT_W(CNT_W), .TOOTH_W(TOOTH_W)) cfg_if ();

    wheel_sim_ctrl #(.CNT_W(CNT_W), .TOOTH_W(TOOTH_W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .cfg        (cfg_if),
        .vrout      (vrout),
        .tooth_idx  (tooth_idx),
        .sync_pulse (sync_pulse),
        .running    (running)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    // Reference model: position within revolution plus active/shadow config
    bit   m_active, m_act_ok, m_pend, m_err, m_fire, m_bad, m_start;
    int   m_pos, m_hp, m_teeth, m_miss, s_hp, s_teeth, s_miss, m_slot;
    exp_t m_e;

    initial begin
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) begin
                m_active = 0; m_act_ok = 0; m_pend = 0; m_err = 0; m_pos = 0;
                m_hp = 0; m_teeth = 0; m_miss = 0;
                exp_q.delete();
            end else begin
                m_fire = cfg_if.cfg_valid && !m_pend;
                m_bad  = (cfg_if.cfg_half_period == 0) || (int'(cfg_if.cfg_teeth) < 2) ||
                         (int'(cfg_if.cfg_missing) >= int'(cfg_if.cfg_teeth));
                if (!m_active) begin
                    m_start = enable && m_act_ok;
                    if (m_pend) begin
                        m_hp = s_hp; m_teeth = s_teeth; m_miss = s_miss;
                        m_act_ok = 1; m_pend = 0;
                    end
                    if (m_start) begin
                        m_active = 1; m_pos = 0;
                    end
                end else if (m_pos == 2 * m_teeth * m_hp - 1) begin
                    if (m_pend) begin
                        m_hp = s_hp; m_teeth = s_teeth; m_miss = s_miss; m_pend = 0;
                    end
                    if (enable) m_pos = 0;
                    else m_active = 0;
                end else begin
                    m_pos++;
                end
                m_err = m_fire && m_bad;
                if (m_fire && !m_bad) begin
                    s_hp    = int'(cfg_if.cfg_half_period);
                    s_teeth = int'(cfg_if.cfg_teeth);
                    s_miss  = int'(cfg_if.cfg_missing);
                    m_pend  = 1;
                end
                m_e = '{vr: 0, tooth: 0, sync: 0, run: 0, rdy: !m_pend, err: m_err};
                if (m_active) begin
                    m_slot    = m_pos / m_hp;
                    m_e.vr    = (m_slot < 2 * (m_teeth - m_miss)) && (m_slot % 2 == 0);
                    m_e.tooth = m_slot / 2;
                    m_e.sync  = (m_pos == 0);
                    m_e.run   = 1;
                end
                exp_q.push_back(m_e);
            end
        end
    end

    exp_t a_e;
    exp_t x_e;

    initial begin
        forever begin
            @(negedge clock);
            if (reset_n) begin
                checks++;
                a_e = '{vr: vrout, tooth: int'(tooth_idx), sync: sync_pulse, run: running,
                        rdy: cfg_if.cfg_ready, err: cfg_if.cfg_err};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_underflow t=%0t no expected entry", $time);
                end else begin
                    x_e = exp_q.pop_front();
                    if (a_e != x_e)
                        begin
                        errors++;
                        $display("FAIL scoreboard t=%0t actual vr=%0b tooth=%0d sync=%0b run=%0b rdy=%0b err=%0b required vr=%0b tooth=%0d sync=%0b run=%0b rdy=%0b err=%0b",
                                 $time, a_e.vr, a_e.tooth, a_e.sync, a_e.run, a_e.rdy, a_e.err,
                                 x_e.vr, x_e.tooth, x_e.sync, x_e.run, x_e.rdy, x_e.err);
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input string name);
        checks++;
        if (vrout !== 1'b0 || tooth_idx !== '0 || sync_pulse !== 1'b0 || running !== 1'b0 ||
            cfg_if.cfg_err !== 1'b0 || cfg_if.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s actual vr=%b tooth=%0d sync=%b run=%b err=%b rdy=%b required 0 0 0 0 0 1",
                     name, vrout, tooth_idx, sync_pulse, running, cfg_if.cfg_err,
                     cfg_if.cfg_ready);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic offer(input int hp, input int teeth, input int miss);
        int waited;
        bit rdy;
        waited = 0;
        cfg_if.cfg_valid       = 1'b1;
        cfg_if.cfg_half_period = CNT_W'(hp);
        cfg_if.cfg_teeth       = TOOTH_W'(teeth);
        cfg_if.cfg_missing     = 4'(miss);
        do begin
            @(negedge clock);
            rdy = cfg_if.cfg_ready;
            @(posedge clock);
            #1;
            waited++;
        end while (!rdy && waited < 1000);
        cfg_if.cfg_valid = 1'b0;
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL offer_timeout actual ready=0 after %0d cycles required ready=1", waited);
        end
    endtask

    task automatic wait_sync();
        int n;
        bit seen;
        seen = 0;
        n = 0;
        while (!seen && n < 500) begin
            @(negedge clock);
            seen = sync_pulse;
            n++;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL sync_timeout actual sync=0 after %0d cycles required sync=1", n);
        end
    endtask

    initial begin
        int r, hp, teeth, miss;
        reset_n = 1'b1;
        enable  = 1'b0;
        cfg_if.cfg_valid       = 1'b0;
        cfg_if.cfg_half_period = '0;
        cfg_if.cfg_teeth       = '0;
        cfg_if.cfg_missing     = '0;
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("reset_initial");
        @(negedge clock);
        #2 reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Enable with no config must stay idle
        enable = 1'b1;
        cycles(5);
        offer(3, 6, 1);
        cycles(80);

        // Rate change mid-revolution waits for the boundary
        cycles(7);
        offer(5, 6, 1);
        cycles(150);

        // Rejected configs
        offer(3, 4, 4);
        cycles(3);
        offer(0, 6, 1);
        cycles(3);
        offer(2, 1, 0);
        cycles(20);

        // Stop mid-revolution, then stop and resume
        wait_sync();
        cycles(25);
        enable = 1'b0;
        cycles(80);
        enable = 1'b1;
        cycles(10);
        enable = 1'b0;
        cycles(12);
        enable = 1'b1;
        cycles(30);

        // Config accepted on the boundary cycle of a 60-clock revolution
        wait_sync();
        cycles(59);
        cfg_if.cfg_valid       = 1'b1;
        cfg_if.cfg_half_period = CNT_W'(2);
        cfg_if.cfg_teeth       = TOOTH_W'(4);
        cfg_if.cfg_missing     = 4'd1;
        cycles(1);
        cfg_if.cfg_valid = 1'b0;
        cycles(130);

        // Edge configs: hp=1 and no missing teeth
        offer(1, 5, 0);
        cycles(40);
        offer(1, 3, 2);
        cycles(30);

        // Asynchronous reset mid-tooth
        @(posedge clock);
        #3 reset_n = 1'b0;
        #1 check_reset_outputs("reset_midtooth");
        @(negedge clock);
        #2 reset_n = 1'b1;
        @(posedge clock);
        #1;
        enable = 1'b1;
        cycles(10);
        offer(2, 4, 1);

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 3));
            hp    = int'($urandom_range(1, 4));
            teeth = int'($urandom_range(2, 8));
            miss  = int'($urandom_range(0, teeth - 1));
            if (r == 0) enable = ~enable;
            else if (r == 3) begin
                if ($urandom_range(0, 1) == 0) hp = 0;
                else miss = teeth + int'($urandom_range(0, 3));
            end
            if (r != 0) offer(hp, teeth, miss);
            cycles(int'($urandom_range(1, 40)));
        end
        enable = 1'b1;
        cycles(70);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
